// File: rtl/detector_frame_stats_pkg.sv
// Shared definitions for the detector frame statistics block:
// register map, bit positions, FSM states and saturating helpers.
package detector_frame_stats_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_SUM    = 3'd2;
  localparam logic [2:0] ADDR_MINMAX = 3'd3;
  localparam logic [2:0] ADDR_PIXCNT = 3'd4;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int STAT_DONE        = 0;
  localparam int STAT_SIZE_ERR    = 1;
  localparam int STAT_RESTART_ERR = 2;

  typedef enum logic {
    S_WAIT_SOP = 1'b0,
    S_IN_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] min;
    logic [15:0] max;
    logic [23:0] cnt;
    logic        size_err;
  } frame_stats_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [23:0] sat_inc24(input logic [23:0] a);
    return (a == 24'hFF_FFFF) ? a : a + 24'd1;
  endfunction

endpackage

// File: rtl/detector_frame_stats_if.sv
// Pixel stream sink and Avalon-MM slave signals of the frame statistics block.
interface detector_frame_stats_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] din_data;
  logic                  din_valid;
  logic                  din_startofpacket;
  logic                  din_endofpacket;
  logic [2:0]            av_address;
  logic                  av_read;
  logic                  av_write;
  logic [31:0]           av_writedata;
  logic [31:0]           av_readdata;
  logic                  irq;

  modport master (
    output din_data, din_valid, din_startofpacket, din_endofpacket,
    output av_address, av_read, av_write, av_writedata,
    input  av_readdata, irq
  );

  modport slave (
    input  din_data, din_valid, din_startofpacket, din_endofpacket,
    input  av_address, av_read, av_write, av_writedata,
    output av_readdata, irq
  );
endinterface

// File: rtl/detector_frame_stats_regs.sv
// Avalon register file: CTRL, W1C status flags, latched frame results,
// registered readdata mux and the level interrupt.
module detector_frame_stats_regs
  import detector_frame_stats_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   i_address,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [31:0]  i_writedata,
  output logic [31:0]  o_readdata,
  output logic         o_irq,
  output logic         o_enable,
  input  logic         i_latch,
  input  logic         i_restart,
  input  frame_stats_t i_stats
);

  logic [1:0]   r_ctrl;
  logic         r_done;
  logic         r_size_err;
  logic         r_restart_err;
  logic [15:0]  r_frame_cnt;
  frame_stats_t r_stats;
  logic [31:0]  r_readdata;
  logic [31:0]  w_rdmux;
  logic [2:0]   w_clr;
  logic         w_wdata_unused;

  assign w_wdata_unused = &{1'b0, i_writedata[31:3]};
  assign w_clr = (i_write && i_address == ADDR_STATUS) ? i_writedata[2:0] : 3'b000;

  always_comb begin
    w_rdmux = 32'd0;
    case (i_address)
      ADDR_CTRL:   w_rdmux = {30'd0, r_ctrl};
      ADDR_STATUS: w_rdmux = {r_frame_cnt, 13'd0, r_restart_err, r_size_err, r_done};
      ADDR_SUM:    w_rdmux = r_stats.sum;
      ADDR_MINMAX: w_rdmux = {r_stats.max, r_stats.min};
      ADDR_PIXCNT: w_rdmux = {8'd0, r_stats.cnt};
      default:     w_rdmux = 32'd0;
    endcase
  end

  // A set from the datapath in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl        <= '0;
      r_done        <= 1'b0;
      r_size_err    <= 1'b0;
      r_restart_err <= 1'b0;
      r_frame_cnt   <= '0;
      r_stats       <= '0;
      r_readdata    <= '0;
    end else begin
      if (i_write && i_address == ADDR_CTRL) r_ctrl <= i_writedata[1:0];
      r_done        <= i_latch | (r_done & ~w_clr[STAT_DONE]);
      r_size_err    <= (i_latch & i_stats.size_err) | (r_size_err & ~w_clr[STAT_SIZE_ERR]);
      r_restart_err <= i_restart | (r_restart_err & ~w_clr[STAT_RESTART_ERR]);
      if (i_latch) begin
        r_stats     <= i_stats;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (i_read) r_readdata <= w_rdmux;
    end
  end

  assign o_readdata = r_readdata;
  assign o_enable   = r_ctrl[CTRL_ENABLE];
  assign o_irq      = r_ctrl[CTRL_IRQ_EN] & r_done;

endmodule

// File: rtl/detector_frame_stats.sv
// Detector frame statistics: per-frame sum/min/max/count accumulated from
// the pixel stream and latched into the register file on the eop beat.
//  state      | meaning
//  S_WAIT_SOP | idle, waiting for a sop beat to start a frame
//  S_IN_FRAME | accumulating pixels until eop (or restart on sop)
module detector_frame_stats
  import detector_frame_stats_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int FRAME_WIDTH  = 384,
  parameter int FRAME_HEIGHT = 288
) (
  input logic clk,
  input logic rst_n,
  detector_frame_stats_if.slave bus
);

  localparam logic [23:0] FRAME_PIX = 24'(FRAME_WIDTH * FRAME_HEIGHT);

  state_t                r_state;
  logic [31:0]           r_sum;
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;
  logic [23:0]           r_cnt;

  logic                  w_enable;
  logic                  w_start;
  logic                  w_cont;
  logic                  w_latch;
  logic                  w_restart;
  logic [DATA_WIDTH-1:0] w_pix;
  logic [31:0]           w_sum_nxt;
  logic [DATA_WIDTH-1:0] w_min_nxt;
  logic [DATA_WIDTH-1:0] w_max_nxt;
  logic [23:0]           w_cnt_nxt;
  frame_stats_t          w_stats;
  logic [31:0]           w_readdata;
  logic                  w_irq;

  // A sop beat always starts a fresh frame, whatever the current state.
  always_comb begin
    w_pix     = bus.din_data;
    w_start   = bus.din_valid & bus.din_startofpacket;
    w_cont    = bus.din_valid & ~bus.din_startofpacket & (r_state == S_IN_FRAME);
    w_sum_nxt = w_start ? 32'(w_pix) : sat_add32(r_sum, 32'(w_pix));
    w_min_nxt = (w_start || w_pix < r_min) ? w_pix : r_min;
    w_max_nxt = (w_start || w_pix > r_max) ? w_pix : r_max;
    w_cnt_nxt = w_start ? 24'd1 : sat_inc24(r_cnt);
    w_latch   = w_enable & bus.din_valid & bus.din_endofpacket & (w_start | w_cont);
    w_restart = w_enable & w_start & (r_state == S_IN_FRAME);
    w_stats.sum      = w_sum_nxt;
    w_stats.min      = 16'(w_min_nxt);
    w_stats.max      = 16'(w_max_nxt);
    w_stats.cnt      = w_cnt_nxt;
    w_stats.size_err = (w_cnt_nxt != FRAME_PIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_SOP;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
    end else if (!w_enable) begin
      r_state <= S_WAIT_SOP;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
    end else if (w_start || w_cont) begin
      r_state <= w_latch ? S_WAIT_SOP : S_IN_FRAME;
      r_sum   <= w_sum_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  detector_frame_stats_regs u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_address   (bus.av_address),
    .i_read      (bus.av_read),
    .i_write     (bus.av_write),
    .i_writedata (bus.av_writedata),
    .o_readdata  (w_readdata),
    .o_irq       (w_irq),
    .o_enable    (w_enable),
    .i_latch     (w_latch),
    .i_restart   (w_restart),
    .i_stats     (w_stats)
  );

  assign bus.av_readdata = w_readdata;
  assign bus.irq         = w_irq;

endmodule

// File: tb/tb_detector_frame_stats.sv
// Scoreboard bench for detector_frame_stats on a reduced 16x8 frame.
module tb_detector_frame_stats;
  import detector_frame_stats_pkg::*;

  localparam int DW = 10;
  localparam int FW = 16;
  localparam int FH = 8;
  localparam int NPIX = FW * FH;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rd_pend = 1'b0;
  exp_t mon_e;

  always #5 clk = ~clk;

  detector_frame_stats_if #(.DATA_WIDTH(DW)) ifc ();

  detector_frame_stats #(
    .DATA_WIDTH  (DW),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= ifc.av_read;

  always @(negedge clk) begin
    if (rd_pend) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_read: got %h, no expectation queued", ifc.av_readdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (ifc.av_readdata !== mon_e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", mon_e.name, ifc.av_readdata, mon_e.exp);
        end
      end
    end
  end

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    sb_q.push_back('{exp, nm});
    @(negedge clk);
    ifc.av_address = a;
    ifc.av_read    = 1'b1;
    @(negedge clk);
    ifc.av_read    = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    ifc.av_address   = a;
    ifc.av_writedata = d;
    ifc.av_write     = 1'b1;
    @(negedge clk);
    ifc.av_write     = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] pix, input logic sop, input logic eop);
    @(negedge clk);
    ifc.din_data          = pix;
    ifc.din_valid         = 1'b1;
    ifc.din_startofpacket = sop;
    ifc.din_endofpacket   = eop;
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.din_valid         = 1'b0;
    ifc.din_startofpacket = 1'b0;
    ifc.din_endofpacket   = 1'b0;
  endtask

  task automatic frame(input int n, input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                       input logic with_eop);
    for (int i = 0; i < n; i++)
      beat((i % 2 == 1) ? pb : pa, i == 0, with_eop && (i == n - 1));
    idle();
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    n_checks++;
    if (ifc.irq !== exp) begin
      n_errors++;
      $display("FAIL %s: irq got %b expected %b", nm, ifc.irq, exp);
    end
  endtask

  task automatic rd_results(input logic [31:0] st, input logic [31:0] sum,
                            input logic [31:0] mm, input logic [31:0] cnt, input string tag);
    rd(ADDR_STATUS, st,  {tag, "_status"});
    rd(ADDR_SUM,    sum, {tag, "_sum"});
    rd(ADDR_MINMAX, mm,  {tag, "_minmax"});
    rd(ADDR_PIXCNT, cnt, {tag, "_pixcnt"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.din_data = '0; ifc.din_valid = 1'b0;
    ifc.din_startofpacket = 1'b0; ifc.din_endofpacket = 1'b0;
    ifc.av_address = '0; ifc.av_read = 1'b0; ifc.av_write = 1'b0; ifc.av_writedata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
    chk_irq(1'b0, "reset_irq");

    wr(ADDR_CTRL, 32'h1);
    rd(ADDR_CTRL, 32'h1, "ctrl_enable");
    frame(NPIX, 10'h155, 10'h155, 1'b1);
    rd_results(32'h0001_0001, 32'h0000_AA80, 32'h0155_0155, NPIX, "flat");
    wr(ADDR_STATUS, 32'h7);
    rd(ADDR_STATUS, 32'h0001_0000, "flat_w1c");

    frame(NPIX, 10'h000, 10'h3FF, 1'b1);
    rd_results(32'h0002_0001, 32'h0000_FFC0, 32'h03FF_0000, NPIX, "alt");
    wr(ADDR_STATUS, 32'h7);

    frame(10, 10'd7, 10'd7, 1'b1);
    beat(10'd99, 1'b0, 1'b1);
    idle();
    rd_results(32'h0003_0003, 32'd70, 32'h0007_0007, 32'd10, "short");
    wr(ADDR_STATUS, 32'h7);

    frame(5, 10'd3, 10'd3, 1'b0);
    frame(NPIX, 10'h155, 10'h155, 1'b1);
    rd_results(32'h0004_0005, 32'h0000_AA80, 32'h0155_0155, NPIX, "restart");
    wr(ADDR_STATUS, 32'h7);

    beat(10'h2A, 1'b1, 1'b1);
    idle();
    rd_results(32'h0005_0003, 32'h2A, 32'h002A_002A, 32'd1, "onepix");
    wr(ADDR_STATUS, 32'h7);

    wr(ADDR_CTRL, 32'h3);
    beat(10'd1, 1'b1, 1'b0);
    beat(10'd2, 1'b0, 1'b0);
    beat(10'd3, 1'b0, 1'b0);
    beat(10'd4, 1'b0, 1'b1);
    chk_irq(1'b0, "irq_before_latch");
    idle();
    chk_irq(1'b1, "irq_rise");
    wr(ADDR_STATUS, 32'h1);
    chk_irq(1'b0, "irq_cleared");
    rd_results(32'h0006_0002, 32'd10, 32'h0004_0001, 32'd4, "irq");
    wr(ADDR_STATUS, 32'h2);

    beat(10'd1, 1'b1, 1'b0);
    beat(10'd2, 1'b0, 1'b0);
    beat(10'd3, 1'b0, 1'b0);
    @(negedge clk);
    ifc.din_data = 10'd4; ifc.din_startofpacket = 1'b0; ifc.din_endofpacket = 1'b1;
    ifc.av_address = ADDR_STATUS; ifc.av_writedata = 32'h1; ifc.av_write = 1'b1;
    @(negedge clk);
    ifc.din_valid = 1'b0; ifc.din_endofpacket = 1'b0; ifc.av_write = 1'b0;
    chk_irq(1'b1, "irq_set_wins");
    rd(ADDR_STATUS, 32'h0007_0003, "set_wins_status");
    wr(ADDR_STATUS, 32'h7);

    beat(10'd5, 1'b1, 1'b0);
    beat(10'd5, 1'b0, 1'b0);
    idle();
    wr(ADDR_CTRL, 32'h2);
    beat(10'd9, 1'b0, 1'b0);
    idle();
    wr(ADDR_CTRL, 32'h3);
    beat(10'd9, 1'b0, 1'b0);
    beat(10'd9, 1'b0, 1'b1);
    idle();
    rd_results(32'h0007_0000, 32'd10, 32'h0004_0001, 32'd4, "disable");
    rd(ADDR_CTRL, 32'h3, "ctrl_reenabled");
    chk_irq(1'b0, "disable_irq");

    beat(10'd5, 1'b1, 1'b0);
    beat(10'd5, 1'b0, 1'b0);
    beat(10'd5, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    ifc.din_valid = 1'b0; ifc.din_startofpacket = 1'b0; ifc.din_endofpacket = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat(10'd9, 1'b0, 1'b0);
    beat(10'd9, 1'b0, 1'b1);
    idle();
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("post_reset_reg%0d", a));
    chk_irq(1'b0, "post_reset_irq");

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
